ttt_turn_controller: RTL and testbench

- Turn-sequencing core of the tic-tac-toe VGA game.
- Built from three parts:
  - a Moore game FSM;
  - a toggle flop holding the current player;
  - a busy detector for the cell under the cursor.
- Consumes button pulses (start, select), a turn timeout, the selected cell's contents and board win/full flags.
- Drives board write-enable, random-position request, player toggle, timer reset and game-wide reset.

---
 rtl/ttt_pkg.sv | 22 ++
 rtl/ttt_player_tff.sv | 16 +
 rtl/ttt_turn_controller.sv | 92 +++++++++
 tb/tb_ttt_turn_controller.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types for the tic-tac-toe turn controller: FSM state codes and cell codes.
package ttt_pkg;

   localparam int          CELL_W     = 2;
   localparam logic [1:0]  CELL_EMPTY = 2'b00;
   localparam logic [1:0]  CELL_P1    = 2'b01;
   localparam logic [1:0]  CELL_P2    = 2'b10;

   // OVER sits outside the 3-bit range so every state keeps a unique debug code
   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_PLAY  = 4'd1,
      S_CHECK = 4'd2,
      S_RAND  = 4'd3,
      S_RCHK  = 4'd4,
      S_WRITE = 4'd5,
      S_EVAL  = 4'd6,
      S_NEXT  = 4'd7,
      S_OVER  = 4'd8
   } state_t;

endpackage

// File: rtl/ttt_player_tff.sv
// Current-player toggle flop: synchronous clear dominates the toggle request.
module ttt_player_tff (
   input  logic clk,
   input  logic clr,
   input  logic tgl,
   output logic q
);

   always_ff @(posedge clk) begin
      if (clr)
         q <= 1'b0;
      else if (tgl)
         q <= ~q;
   end

endmodule

// File: rtl/ttt_turn_controller.sv
// Turn sequencing for the tic-tac-toe game: Moore FSM, player flop and busy-cell decode.
module ttt_turn_controller
   import ttt_pkg::*;
#(
   parameter int CELL_W = 2
) (
   input  logic              clk,
   input  logic              hrd_rst,
   input  logic              start,
   input  logic              select,
   input  logic              timeout,
   input  logic [CELL_W-1:0] cell_state,
   input  logic              win,
   input  logic              full,
   output logic              gen_rand,
   output logic              toggle_player,
   output logic              w_e,
   output logic              rst_timer,
   output logic              rst,
   output logic              is_busy,
   output logic              cur_player,
   output logic [1:0]        player,
   output logic              game_over,
   output logic [3:0]        fsm_state
);

   state_t state, state_nxt;

   assign is_busy   = |cell_state;
   assign player    = {1'b0, cur_player} + 2'd1;
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (hrd_rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      gen_rand      = 1'b0;
      toggle_player = 1'b0;
      w_e           = 1'b0;
      rst_timer     = 1'b0;
      rst           = 1'b0;
      game_over     = 1'b0;
      unique case (state)
         S_IDLE: begin
            rst       = 1'b1;
            rst_timer = 1'b1;
            if (start) state_nxt = S_PLAY;
         end
         // select wins over a timeout arriving in the same cycle
         S_PLAY: begin
            if (select)       state_nxt = S_CHECK;
            else if (timeout) state_nxt = S_RAND;
         end
         S_CHECK: state_nxt = is_busy ? S_PLAY : S_WRITE;
         S_RAND: begin
            gen_rand  = 1'b1;
            state_nxt = S_RCHK;
         end
         S_RCHK:  state_nxt = is_busy ? S_RAND : S_WRITE;
         S_WRITE: begin
            w_e       = 1'b1;
            state_nxt = S_EVAL;
         end
         // board flags reflect the write one cycle later, so they are sampled here
         S_EVAL:  state_nxt = (win | full) ? S_OVER : S_NEXT;
         S_NEXT: begin
            toggle_player = 1'b1;
            rst_timer     = 1'b1;
            state_nxt     = S_PLAY;
         end
         S_OVER: begin
            game_over = 1'b1;
            rst_timer = 1'b1;
            if (start) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   ttt_player_tff u_player (
      .clk (clk),
      .clr (rst | hrd_rst),
      .tgl (toggle_player),
      .q   (cur_player)
   );

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Directed vector bench for ttt_turn_controller: one long table scenario plus corner sequences.
module tb_ttt_turn_controller;

   logic       clk = 1'b0;
   logic       hrd_rst = 1'b0, start = 1'b0, select = 1'b0, timeout = 1'b0;
   logic       win = 1'b0, full = 1'b0;
   logic [1:0] cell_state = 2'b00;
   logic       gen_rand, toggle_player, w_e, rst_timer, rst, is_busy, cur_player, game_over;
   logic [1:0] player;
   logic [3:0] fsm_state;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ttt_turn_controller #(.CELL_W(2)) dut (
      .clk(clk), .hrd_rst(hrd_rst), .start(start), .select(select), .timeout(timeout),
      .cell_state(cell_state), .win(win), .full(full), .gen_rand(gen_rand),
      .toggle_player(toggle_player), .w_e(w_e), .rst_timer(rst_timer), .rst(rst),
      .is_busy(is_busy), .cur_player(cur_player), .player(player), .game_over(game_over),
      .fsm_state(fsm_state)
   );

   // inputs {hrd_rst,start,select,timeout}, expected Moore outputs
   // {gen_rand,toggle_player,w_e,rst_timer,rst,game_over}
   localparam logic [3:0] I_NO = 4'b0000, I_HR = 4'b1000, I_ST = 4'b0100,
                          I_SEL = 4'b0010, I_TO = 4'b0001, I_SELTO = 4'b0011;
   localparam logic [5:0] O_IDLE = 6'b000110, O_NONE = 6'b000000, O_RAND = 6'b100000,
                          O_WRITE = 6'b001000, O_NEXT = 6'b010100, O_OVER = 6'b000101;

   typedef struct packed {
      logic [3:0] in;
      logic [1:0] cs;
      logic [1:0] wf;
      logic [3:0] s;
      logic [5:0] o;
      logic       cp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic [3:0] in, input logic [1:0] cs, input logic [1:0] wf,
                              input logic [3:0] s, input logic [5:0] o, input logic cp);
      vec_t r;
      r.in = in; r.cs = cs; r.wf = wf; r.s = s; r.o = o; r.cp = cp;
      return r;
   endfunction

   task automatic set_in(input logic [3:0] in, input logic [1:0] cs, input logic [1:0] wf);
      {hrd_rst, start, select, timeout} = in;
      cell_state = cs;
      {win, full} = wf;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin
      // reset and first move
      tbl.push_back(v(I_HR,    2'b00, 2'b00, 4'd0, O_IDLE,  1'b0));
      tbl.push_back(v(I_NO,    2'b00, 2'b00, 4'd0, O_IDLE,  1'b0));
      tbl.push_back(v(I_ST,    2'b00, 2'b00, 4'd1, O_NONE,  1'b0));
      tbl.push_back(v(I_NO,    2'b00, 2'b00, 4'd1, O_NONE,  1'b0));
      tbl.push_back(v(I_SEL,   2'b00, 2'b00, 4'd2, O_NONE,  1'b0));
      tbl.push_back(v(I_NO,    2'b00, 2'b00, 4'd5, O_WRITE, 1'b0));
      tbl.push_back(v(I_NO,    2'b00, 2'b00, 4'd6, O_NONE,  1'b0));
      tbl.push_back(v(I_NO,    2'b00, 2'b00, 4'd7, O_NEXT,  1'b0));
      tbl.push_back(v(I_NO,    2'b00, 2'b00, 4'd1, O_NONE,  1'b1));
      // busy cell: move rejected
      tbl.push_back(v(I_SEL,   2'b01, 2'b00, 4'd2, O_NONE,  1'b1));
      tbl.push_back(v(I_NO,    2'b01, 2'b00, 4'd1, O_NONE,  1'b1));
      tbl.push_back(v(I_NO,    2'b00, 2'b00, 4'd1, O_NONE,  1'b1));
      // timeout: first random cell busy, second free
      tbl.push_back(v(I_TO,    2'b00, 2'b00, 4'd3, O_RAND,  1'b1));
      tbl.push_back(v(I_TO,    2'b01, 2'b00, 4'd4, O_NONE,  1'b1));
      tbl.push_back(v(I_TO,    2'b01, 2'b00, 4'd3, O_RAND,  1'b1));
      tbl.push_back(v(I_TO,    2'b00, 2'b00, 4'd4, O_NONE,  1'b1));
      tbl.push_back(v(I_TO,    2'b00, 2'b00, 4'd5, O_WRITE, 1'b1));
      tbl.push_back(v(I_TO,    2'b00, 2'b00, 4'd6, O_NONE,  1'b1));
      tbl.push_back(v(I_TO,    2'b00, 2'b00, 4'd7, O_NEXT,  1'b1));
      tbl.push_back(v(I_NO,    2'b00, 2'b00, 4'd1, O_NONE,  1'b0));
      // win: OVER, player frozen, two-step restart
      tbl.push_back(v(I_SEL,   2'b00, 2'b00, 4'd2, O_NONE,  1'b0));
      tbl.push_back(v(I_NO,    2'b00, 2'b00, 4'd5, O_WRITE, 1'b0));
      tbl.push_back(v(I_NO,    2'b00, 2'b00, 4'd6, O_NONE,  1'b0));
      tbl.push_back(v(I_NO,    2'b00, 2'b10, 4'd8, O_OVER,  1'b0));
      tbl.push_back(v(I_NO,    2'b00, 2'b10, 4'd8, O_OVER,  1'b0));
      tbl.push_back(v(I_ST,    2'b00, 2'b00, 4'd0, O_IDLE,  1'b0));
      tbl.push_back(v(I_ST,    2'b00, 2'b00, 4'd1, O_NONE,  1'b0));
      // select + timeout together, then hard reset mid-WRITE
      tbl.push_back(v(I_SELTO, 2'b00, 2'b00, 4'd2, O_NONE,  1'b0));
      tbl.push_back(v(I_TO,    2'b00, 2'b00, 4'd5, O_WRITE, 1'b0));
      tbl.push_back(v(I_HR,    2'b00, 2'b00, 4'd0, O_IDLE,  1'b0));
      // win and full together
      tbl.push_back(v(I_ST,    2'b00, 2'b00, 4'd1, O_NONE,  1'b0));
      tbl.push_back(v(I_SEL,   2'b00, 2'b00, 4'd2, O_NONE,  1'b0));
      tbl.push_back(v(I_NO,    2'b00, 2'b00, 4'd5, O_WRITE, 1'b0));
      tbl.push_back(v(I_NO,    2'b00, 2'b00, 4'd6, O_NONE,  1'b0));
      tbl.push_back(v(I_NO,    2'b00, 2'b11, 4'd8, O_OVER,  1'b0));

      for (int i = 0; i < tbl.size(); i++) begin
         logic [13:0] act, exp;
         set_in(tbl[i].in, tbl[i].cs, tbl[i].wf);
         tick();
         act = {fsm_state, gen_rand, toggle_player, w_e, rst_timer, rst, game_over,
                is_busy, cur_player, player};
         exp = {tbl[i].s, tbl[i].o, (tbl[i].cs != 2'b00), tbl[i].cp,
                (tbl[i].cp ? 2'd2 : 2'd1)};
         chk($sformatf("vec%0d", i), {2'b00, act}, {2'b00, exp});
      end

      // full alone ends the game
      set_in(I_ST, 2'b00, 2'b00);  tick();
      set_in(I_ST, 2'b00, 2'b00);  tick();
      set_in(I_SEL, 2'b00, 2'b00); tick();
      set_in(I_NO, 2'b00, 2'b00);  tick();
      chk("full_write", {15'd0, w_e}, 16'd1);
      tick();
      set_in(I_NO, 2'b00, 2'b01);  tick();
      chk("full_over", {12'd0, fsm_state}, 16'd8);
      chk("full_no_toggle", {15'd0, toggle_player}, 16'd0);

      // hard reset coinciding with the toggle pulse: clear wins
      set_in(I_ST, 2'b00, 2'b00);  tick();
      set_in(I_ST, 2'b00, 2'b00);  tick();
      set_in(I_SEL, 2'b00, 2'b00); tick();
      set_in(I_NO, 2'b00, 2'b00);  tick(); tick(); tick();
      chk("next_toggle", {15'd0, toggle_player}, 16'd1);
      set_in(I_HR, 2'b00, 2'b00);  tick();
      chk("clr_state", {12'd0, fsm_state}, 16'd0);
      chk("clr_over_toggle", {15'd0, cur_player}, 16'd0);

      // timeout auto-move with a bounded wait for the next turn
      begin
         int  we_n, gr_n;
         bit  done;
         set_in(I_ST, 2'b00, 2'b00); tick();
         set_in(I_TO, 2'b00, 2'b00); tick();
         we_n = 0; gr_n = int'(gen_rand); done = 1'b0;
         for (int i = 0; i < 12 && !done; i++) begin
            tick();
            we_n += int'(w_e);
            gr_n += int'(gen_rand);
            if (fsm_state == 4'd1) done = 1'b1;
         end
         set_in(I_NO, 2'b00, 2'b00);
         chk("auto_done", {15'd0, done}, 16'd1);
         chk("auto_we_cnt", we_n[15:0], 16'd1);
         chk("auto_gr_cnt", gr_n[15:0], 16'd1);
         chk("auto_player", {14'd0, player}, 16'd2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
